// File: rtl/deserializer.sv
// Multi-lane serial-to-parallel converter with per-word bit order, valid/ready output register and overflow flag.
// Latency: word valid the cycle after its last beat; a full output register with i_rdy low drops new words and sets o_ovf.
// Frame-sync realignment (i_sync, o_slp) is built only when DESERIALIZER_SYNC_EN is defined.
module deserializer #(
    parameter int p_width = 8,
    parameter int p_lanes = 1,
    localparam int N = p_width / p_lanes,
    localparam int C = (N > 1) ? $clog2(N) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_lanes-1:0] i_val,
    input  logic               i_stp,
    input  logic               i_msb,
    input  logic               i_sync,
    input  logic               i_rdy,
    input  logic               i_clr,
    output logic [p_width-1:0] o_val,
    output logic               o_stp,
    output logic [C-1:0]       o_cnt,
    output logic               o_ovf,
    output logic               o_slp
);

    localparam logic [C-1:0] LAST = C'(N - 1);

    logic [C-1:0]       cnt;
    logic [C-1:0]       cnt_base;
    logic [C-1:0]       cnt_nxt;
    logic               ord;
    logic               ord_use;
    logic               sync_hit;
    logic               first;
    logic               last;
    logic               load;
    logic               ovf_set;
    logic [p_width-1:0] word;

`ifdef DESERIALIZER_SYNC_EN
    assign sync_hit = i_sync & i_stp;
`else
    logic sync_unused;
    assign sync_unused = i_sync;
    assign sync_hit    = 1'b0;
`endif

    // A sync beat restarts the word: it behaves exactly like beat 0.
    assign cnt_base = sync_hit ? '0 : cnt;
    assign first    = (cnt_base == '0);
    assign ord_use  = first ? i_msb : ord;
    assign last     = i_stp & (cnt_base == LAST);
    assign cnt_nxt  = last ? '0 : cnt_base + C'(1);

    generate
        if (N == 1) begin : g_direct
            assign word = i_val;
        end else begin : g_shift
            logic [p_width-1:0] sh;

            always_comb begin
                word = ord_use ? {sh[p_width-p_lanes-1:0], i_val}
                               : {i_val, sh[p_width-1:p_lanes]};
            end

            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    sh <= '0;
                end else if (i_stp) begin
                    sh <= word;
                end
            end
        end
    endgenerate

    assign load    = last & (~o_stp | i_rdy);
    assign ovf_set = last & o_stp & ~i_rdy;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt   <= '0;
            ord   <= 1'b1;
            o_val <= '0;
            o_stp <= 1'b0;
            o_ovf <= 1'b0;
            o_slp <= 1'b0;
        end else begin
            if (i_stp) begin
                cnt <= cnt_nxt;
                ord <= ord_use;
            end
            if (load) begin
                o_val <= word;
                o_stp <= 1'b1;
            end else if (o_stp & i_rdy) begin
                o_stp <= 1'b0;
            end
            // Setting beats clearing when both land in one cycle.
            if (ovf_set) begin
                o_ovf <= 1'b1;
            end else if (i_clr) begin
                o_ovf <= 1'b0;
            end
            o_slp <= sync_hit & (cnt != '0);
        end
    end

    assign o_cnt = cnt;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (p_width=8, p_lanes=2) with a scoreboard of accepted words.
module tb_deserializer;

    logic       clk;
    logic       rst;
    logic [1:0] val;
    logic       stp;
    logic       msb;
    logic       sync;
    logic       rdy;
    logic       clr;
    logic [7:0] o_val;
    logic       o_stp;
    logic [1:0] o_cnt;
    logic       o_ovf;
    logic       o_slp;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sbq[$];

    deserializer #(.p_width(8), .p_lanes(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_val (val),
        .i_stp (stp),
        .i_msb (msb),
        .i_sync(sync),
        .i_rdy (rdy),
        .i_clr (clr),
        .o_val (o_val),
        .o_stp (o_stp),
        .o_cnt (o_cnt),
        .o_ovf (o_ovf),
        .o_slp (o_slp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: score any handshake at mid-cycle, then step past the edge.
    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        if (o_stp && rdy) begin
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected: observed=%0h expected=none", o_val);
            end
            if (sbq.size() != 0) begin
                exp = sbq.pop_front();
                check("sb_word", o_val, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] d);
        val = d;
        stp = 1'b1;
        tick();
        stp = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b0; val = '0; stp = 1'b0; msb = 1'b1; sync = 1'b0; rdy = 1'b1; clr = 1'b0;
        idle(2);
        check("rst_val", o_val, 8'h00);
        check("rst_stp", o_stp, 1'b0);
        check("rst_cnt", o_cnt, 2'd0);
        check("rst_ovf", o_ovf, 1'b0);
        check("rst_slp", o_slp, 1'b0);
        rst = 1'b1;
        idle(1);

        // MSB-first word, valid for exactly one cycle
        msb = 1'b1;
        beat(2'b10); beat(2'b11); beat(2'b00);
        sbq.push_back(8'hB1);
        beat(2'b01);
        check("msb_val", o_val, 8'hB1);
        check("msb_stp", o_stp, 1'b1);
        check("msb_cnt", o_cnt, 2'd0);
        idle(1);
        check("msb_stp_drop", o_stp, 1'b0);

        // LSB-first word
        msb = 1'b0;
        beat(2'b10); beat(2'b11); beat(2'b00);
        sbq.push_back(8'h4E);
        beat(2'b01);
        check("lsb_val", o_val, 8'h4E);

        // Order toggled mid-word keeps beat-0 order
        msb = 1'b1;
        beat(2'b10);
        msb = 1'b0;
        beat(2'b11); beat(2'b00);
        sbq.push_back(8'hB1);
        beat(2'b01);
        check("toggle_val", o_val, 8'hB1);
        idle(1);

        // Backpressure: A held, B dropped, set beats a simultaneous clear
        rdy = 1'b0; msb = 1'b1;
        beat(2'b00); beat(2'b01); beat(2'b10);
        sbq.push_back(8'h1B);
        beat(2'b11);
        beat(2'b11); beat(2'b11); beat(2'b00);
        clr = 1'b1;
        beat(2'b00);
        clr = 1'b0;
        check("bp_val", o_val, 8'h1B);
        check("bp_stp", o_stp, 1'b1);
        check("bp_ovf", o_ovf, 1'b1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("bp_clr", o_ovf, 1'b0);
        rdy = 1'b1;
        idle(1);
        check("bp_accept", o_stp, 1'b0);

        // Accept on completion: B loads while A is taken
        rdy = 1'b0;
        beat(2'b00); beat(2'b01); beat(2'b10);
        sbq.push_back(8'h1B);
        beat(2'b11);
        beat(2'b01); beat(2'b01); beat(2'b01);
        rdy = 1'b1;
        sbq.push_back(8'h55);
        beat(2'b01);
        check("aoc_val", o_val, 8'h55);
        check("aoc_stp", o_stp, 1'b1);
        check("aoc_ovf", o_ovf, 1'b0);
        idle(1);

        // Frame sync mid-word
        beat(2'b01);
        check("sync_cnt0", o_cnt, 2'd1);
        beat(2'b10);
        check("sync_cnt1", o_cnt, 2'd2);
        sync = 1'b1;
        beat(2'b11);
        sync = 1'b0;
`ifdef DESERIALIZER_SYNC_EN
        check("sync_cnt2", o_cnt, 2'd1);
        check("sync_slp", o_slp, 1'b1);
        beat(2'b00);
        check("sync_slp_end", o_slp, 1'b0);
        check("sync_cnt3", o_cnt, 2'd2);
        beat(2'b00);
        check("sync_cnt4", o_cnt, 2'd3);
        sbq.push_back(8'hC0);
        beat(2'b00);
        check("sync_cnt5", o_cnt, 2'd0);
        check("sync_val", o_val, 8'hC0);
`else
        check("nosync_cnt2", o_cnt, 2'd3);
        check("nosync_slp", o_slp, 1'b0);
        sbq.push_back(8'h6C);
        beat(2'b00);
        check("nosync_cnt3", o_cnt, 2'd0);
        check("nosync_val", o_val, 8'h6C);
        beat(2'b00); beat(2'b00); beat(2'b00);
        sbq.push_back(8'h00);
        beat(2'b00);
        check("nosync_val2", o_val, 8'h00);
`endif
        // Sync without a strobe does nothing
        sync = 1'b1;
        idle(1);
        sync = 1'b0;
        check("sync_nostp_slp", o_slp, 1'b0);
        check("sync_nostp_cnt", o_cnt, 2'd0);

        // Reset mid-word with a word pending
        rdy = 1'b0;
        beat(2'b10); beat(2'b10); beat(2'b10); beat(2'b10);
        beat(2'b01); beat(2'b01); beat(2'b01);
        check("pre_rst_stp", o_stp, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_val", o_val, 8'h00);
        check("arst_stp", o_stp, 1'b0);
        check("arst_cnt", o_cnt, 2'd0);
        beat(2'b11);
        check("rst_beat_ignored", o_cnt, 2'd0);
        rst = 1'b1;
        rdy = 1'b1;
        beat(2'b11); beat(2'b10); beat(2'b01);
        check("post_rst_stp", o_stp, 1'b0);
        sbq.push_back(8'hE4);
        beat(2'b00);
        check("post_rst_val", o_val, 8'hE4);
        idle(3);
        check("post_rst_idle", o_stp, 1'b0);
        check("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
